// File: rtl/data_splitter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_splitter_pkg
// Purpose  : Shared defaults and FSM state encoding for data_splitter_nch.
// Revision : 1.0 - initial release
// ============================================================================
package data_splitter_pkg;

   localparam int DEF_DW  = 32;
   localparam int DEF_NCH = 4;
   localparam int DEF_CW  = 16;

   // FSM state encoding, kept as plain constants for legacy tool flows
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_POP  = 3'd1;
   localparam state_t S_CAPT = 3'd2;
   localparam state_t S_PUSH = 3'd3;
   localparam state_t S_FIN  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/data_splitter_nch_if.sv
`default_nettype none
// ============================================================================
// Module   : data_splitter_nch_if
// Purpose  : Source-FIFO read port plus NCH sink-FIFO write ports.
//            master = splitter side, slave = FIFO/environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface data_splitter_nch_if
   import data_splitter_pkg::*;
#(
   parameter int DW  = DEF_DW,
   parameter int NCH = DEF_NCH
);
   logic              idata_rdy;
   logic [DW-1:0]     idata;
   logic              idata_pop;
   logic [NCH-1:0]    odata_rdy;
   logic [NCH-1:0]    odata_push;
   logic [NCH*DW-1:0] odata;

   modport master (
      input  idata_rdy, idata, odata_rdy,
      output idata_pop, odata_push, odata
   );

   modport slave (
      output idata_rdy, idata, odata_rdy,
      input  idata_pop, odata_push, odata
   );
endinterface
`default_nettype wire

// File: rtl/dsplit_next_ch.sv
`default_nettype none
// ============================================================================
// Module   : dsplit_next_ch
// Purpose  : Cyclic priority search: first set mask bit strictly after cur_i,
//            wrapping; returns cur_i itself if it is the only set bit.
// Revision : 1.0 - initial release
// ============================================================================
module dsplit_next_ch #(
   parameter int NCH = 4,
   parameter int IW  = 2
) (
   input  wire logic [NCH-1:0] mask_i,
   input  wire logic [IW-1:0]  cur_i,
   output logic      [IW-1:0]  nxt_o,
   output logic                any_o
);

   logic [IW-1:0] w_idx;

   // Scan from the farthest offset down so the nearest set bit wins
   always_comb begin
      int unsigned t;
      nxt_o = cur_i;
      w_idx = '0;
      for (int i = NCH; i >= 1; i--) begin
         t = 32'(cur_i) + 32'(i);
         if (t >= 32'(NCH)) t = t - 32'(NCH);
         w_idx = IW'(t);
         if (mask_i[w_idx]) nxt_o = w_idx;
      end
   end

   assign any_o = |mask_i;

endmodule
`default_nettype wire

// File: rtl/data_splitter_nch.sv
`default_nettype none
// ============================================================================
// Module   : data_splitter_nch
// Purpose  : Pops words from a source FIFO and deals them round-robin to NCH
//            sink FIFOs in per-channel bursts until cfg_num words have moved.
//            Optional macro DATA_SPLITTER_NCH_STATS_EN adds per-channel
//            free-running 32-bit push counters on stat_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module data_splitter_nch
   import data_splitter_pkg::*;
#(
   parameter int DW  = DEF_DW,
   parameter int NCH = DEF_NCH,
   parameter int CW  = DEF_CW
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              start,
   input  wire logic [CW-1:0]     cfg_num,
   input  wire logic [NCH*CW-1:0] cfg_burst,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err,
   data_splitter_nch_if.master    bus
`ifdef DATA_SPLITTER_NCH_STATS_EN
   ,output logic [NCH*32-1:0]     stat_cnt
`endif
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   state_t              state_q, state_d;
   logic [NCH*CW-1:0]   burst_q, burst_d;
   logic [IW-1:0]       ch_q, ch_d;
   logic [CW-1:0]       bcnt_q, bcnt_d;
   logic [CW-1:0]       rem_q, rem_d;
   logic [DW-1:0]       data_q, data_d;
   logic                cfg_err_q, cfg_err_d;

   logic [NCH-1:0]      w_mask_cfg, w_mask_sh, w_nc_mask;
   logic [IW-1:0]       w_nc_cur, w_nxt;
   logic                w_any;
   logic [CW-1:0]       w_cur_burst;
   logic                w_push_ok;
   logic [NCH-1:0]      w_push;

   // Nonzero-burst masks for the incoming config and the latched shadow copy
   for (genvar k = 0; k < NCH; k++) begin : g_mask
      assign w_mask_cfg[k] = |cfg_burst[k*CW +: CW];
      assign w_mask_sh[k]  = |burst_q[k*CW +: CW];
   end

   // At start the search begins "after" the last channel so index 0 is first
   assign w_nc_mask = (state_q == S_IDLE) ? w_mask_cfg : w_mask_sh;
   assign w_nc_cur  = (state_q == S_IDLE) ? IW'(NCH - 1) : ch_q;

   dsplit_next_ch #(
      .NCH (NCH),
      .IW  (IW)
   ) u_next_ch (
      .mask_i (w_nc_mask),
      .cur_i  (w_nc_cur),
      .nxt_o  (w_nxt),
      .any_o  (w_any)
   );

   assign w_cur_burst = burst_q[ch_q*CW +: CW];
   assign w_push_ok   = (state_q == S_PUSH) && bus.odata_rdy[ch_q];

   // Next-state and datapath update
   always_comb begin
      state_d   = state_q;
      burst_d   = burst_q;
      ch_d      = ch_q;
      bcnt_d    = bcnt_q;
      rem_d     = rem_q;
      data_d    = data_q;
      cfg_err_d = cfg_err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               burst_d   = cfg_burst;
               cfg_err_d = 1'b0;
               if (cfg_num == '0) begin
                  state_d = S_FIN;
               end else if (!w_any) begin
                  cfg_err_d = 1'b1;
                  state_d   = S_FIN;
               end else begin
                  ch_d    = w_nxt;
                  bcnt_d  = '0;
                  rem_d   = cfg_num;
                  state_d = S_POP;
               end
            end
         end
         S_POP: begin
            if (bus.idata_rdy) state_d = S_CAPT;
         end
         S_CAPT: begin
            data_d  = bus.idata;
            state_d = S_PUSH;
         end
         S_PUSH: begin
            if (w_push_ok) begin
               rem_d = rem_q - 1'b1;
               if (CW'(bcnt_q + 1'b1) == w_cur_burst) begin
                  bcnt_d = '0;
                  ch_d   = w_nxt;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
               state_d = (rem_q == CW'(1)) ? S_FIN : S_POP;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         burst_q   <= '0;
         ch_q      <= '0;
         bcnt_q    <= '0;
         rem_q     <= '0;
         data_q    <= '0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         burst_q   <= burst_d;
         ch_q      <= ch_d;
         bcnt_q    <= bcnt_d;
         rem_q     <= rem_d;
         data_q    <= data_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   // One-hot push strobe, combinational from the active channel's ready
   always_comb begin
      w_push = '0;
      if (w_push_ok) w_push[ch_q] = 1'b1;
   end

   assign bus.idata_pop  = (state_q == S_POP) && bus.idata_rdy;
   assign bus.odata_push = w_push;
   assign bus.odata      = {NCH{data_q}};
   assign busy           = (state_q != S_IDLE);
   assign done           = (state_q == S_FIN);
   assign cfg_err        = cfg_err_q;

`ifdef DATA_SPLITTER_NCH_STATS_EN
   for (genvar k = 0; k < NCH; k++) begin : g_stats
      logic [31:0] cnt_q;
      // Free-running per-channel push counter, cleared only by reset
      always_ff @(posedge clk) begin
         if (rst)            cnt_q <= '0;
         else if (w_push[k]) cnt_q <= cnt_q + 32'd1;
      end
      assign stat_cnt[k*32 +: 32] = cnt_q;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_splitter_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_splitter_nch
// Purpose  : Scoreboard bench for data_splitter_nch (NCH=4, DW=32, CW=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_splitter_nch;

   localparam int DW  = 32;
   localparam int NCH = 4;
   localparam int CW  = 16;
   localparam logic [DW-1:0] WBASE = 32'hA500_0000;

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic [CW-1:0]     cfg_num;
   logic [NCH*CW-1:0] cfg_burst;
   logic              busy;
   logic              done;
   logic              cfg_err;
`ifdef DATA_SPLITTER_NCH_STATS_EN
   logic [NCH*32-1:0] stat_cnt;
`endif

   data_splitter_nch_if #(.DW(DW), .NCH(NCH)) bus ();

   data_splitter_nch #(.DW(DW), .NCH(NCH), .CW(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cfg_num   (cfg_num),
      .cfg_burst (cfg_burst),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err),
      .bus       (bus)
`ifdef DATA_SPLITTER_NCH_STATS_EN
      ,.stat_cnt (stat_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks    = 0;
   int   failures  = 0;
   exp_t exp_q[$];
   int   src_idx   = 0;
   int   busy_cyc  = 0;
   int   done_cnt  = 0;
   int   pop_cnt   = 0;
   int   push_cnt  = 0;
   int   obs_push[NCH];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: checks every pop and push, and models the source FIFO read latency
   initial begin
      logic pop_seen;
      exp_t e;
      forever begin
         @(negedge clk);
         pop_seen = bus.idata_pop;
         if (busy) busy_cyc++;
         if (done) done_cnt++;
         if (pop_seen) begin
            pop_cnt++;
            chk("pop_only_when_rdy", 64'(bus.idata_rdy), 64'd1);
         end
         if (|bus.odata_push) begin
            chk("push_onehot", 64'($onehot(bus.odata_push)), 64'd1);
            for (int k = 0; k < NCH; k++) begin
               if (bus.odata_push[k]) begin
                  push_cnt++;
                  obs_push[k]++;
                  if (exp_q.size() == 0) begin
                     chk("push_unexpected", 64'(k), 64'hFFFF);
                  end else begin
                     e = exp_q.pop_front();
                     chk("push_ch", 64'(k), 64'(e.ch));
                     chk("push_data", 64'(bus.odata[k*DW +: DW]), 64'(e.data));
                  end
               end
            end
         end
         @(posedge clk);
         #1;
         if (pop_seen) begin
            bus.idata = WBASE + DW'(src_idx);
            src_idx++;
         end
      end
   end

   task automatic clr_counts();
      busy_cyc = 0;
      done_cnt = 0;
      pop_cnt  = 0;
      push_cnt = 0;
   endtask

   // Queue the hand-computed channel sequence, then pulse start
   task automatic run(input logic [CW-1:0] num, input logic [NCH*CW-1:0] bursts,
                      input int n, input int chs[16]);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.ch   = chs[i];
         e.data = WBASE + DW'(src_idx + i);
         exp_q.push_back(e);
      end
      clr_counts();
      @(posedge clk);
      #1;
      cfg_num   = num;
      cfg_burst = bursts;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      cfg_num   = '1;
      cfg_burst = '1;
   endtask

   // Wait for the done pulse; optionally toggles idata_rdy 1,0,1,1,0 meanwhile
   task automatic wait_done(input int bound, input bit toggle);
      int c;
      logic pat[5];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      c = 0;
      while (done_cnt == 0 && c < bound) begin
         @(posedge clk);
         #1;
         if (toggle) bus.idata_rdy = pat[c % 5];
         c++;
      end
      chk("done_seen", 64'(done_cnt != 0), 64'd1);
      @(posedge clk);
      #1;
      bus.idata_rdy = 1'b1;
   endtask

   initial begin
      int seq_a[16] = '{0,0,1,3,3,3,0,0,1,3,3,3,0,0,0,0};
      int seq_h[16] = '{0,1,1,0,1,1,0,0,0,0,0,0,0,0,0,0};
      int seq_r[16] = '{0,1,2,3,0,1,2,3,0,0,0,0,0,0,0,0};
      int none[16]  = '{default: 0};
      int base, p0, q0, c;

      for (int k = 0; k < NCH; k++) obs_push[k] = 0;
      rst           = 1'b1;
      start         = 1'b0;
      cfg_num       = '0;
      cfg_burst     = '0;
      bus.idata_rdy = 1'b1;
      bus.idata     = '0;
      bus.odata_rdy = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_cfg_err", 64'(cfg_err), 64'd0);
      chk("rst_pop", 64'(bus.idata_pop), 64'd0);
      chk("rst_push", 64'(bus.odata_push), 64'd0);
      chk("rst_odata", 64'(bus.odata != '0), 64'd0);
      rst = 1'b0;

      // Bursts {2,1,0,3}, 12 words, sinks always ready
      run(16'd12, {16'd3, 16'd0, 16'd1, 16'd2}, 12, seq_a);
      wait_done(200, 1'b0);
      chk("a_busy_cycles", 64'(busy_cyc), 64'd37);
      chk("a_done_cnt", 64'(done_cnt), 64'd1);
      chk("a_pops", 64'(pop_cnt), 64'd12);
      chk("a_queue_empty", 64'(exp_q.size()), 64'd0);

      // Zero-length run
      run(16'd0, {4{16'd1}}, 0, none);
      wait_done(20, 1'b0);
      chk("z_busy_cycles", 64'(busy_cyc), 64'd1);
      chk("z_pops", 64'(pop_cnt), 64'd0);
      chk("z_pushes", 64'(push_cnt), 64'd0);
      chk("z_cfg_err", 64'(cfg_err), 64'd0);

      // All bursts zero with nonzero count flags a config error
      run(16'd5, '0, 0, none);
      wait_done(20, 1'b0);
      chk("e_cfg_err", 64'(cfg_err), 64'd1);
      chk("e_pops", 64'(pop_cnt), 64'd0);
      chk("e_done_cnt", 64'(done_cnt), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("e_cfg_err_sticky", 64'(cfg_err), 64'd1);

      // Channel 1 backpressure for 10 cycles in the middle of its burst
      bus.odata_rdy = 4'b1101;
      base = src_idx;
      run(16'd6, {16'd0, 16'd0, 16'd2, 16'd1}, 6, seq_h);
      c = 0;
      while ((src_idx - base) < 2 && c < 50) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk("h_reached_hold", 64'(src_idx - base), 64'd2);
      @(posedge clk);
      #1;
      p0 = pop_cnt;
      q0 = push_cnt;
      repeat (10) @(posedge clk);
      #1;
      chk("h_no_push", 64'(push_cnt), 64'(q0));
      chk("h_no_pop", 64'(pop_cnt), 64'(p0));
      chk("h_busy", 64'(busy), 64'd1);
      chk("h_lane1_data", 64'(bus.odata[1*DW +: DW]), 64'(WBASE + DW'(base + 1)));
      bus.odata_rdy = 4'b1111;
      wait_done(100, 1'b0);
      chk("h_cfg_err_cleared", 64'(cfg_err), 64'd0);
      chk("h_pops", 64'(pop_cnt), 64'd6);
      chk("h_queue_empty", 64'(exp_q.size()), 64'd0);

      // Source ready toggling
      run(16'd8, {4{16'd1}}, 8, seq_r);
      wait_done(200, 1'b1);
      chk("t_pops", 64'(pop_cnt), 64'd8);
      chk("t_pushes", 64'(push_cnt), 64'd8);
      chk("t_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset while a popped word sits in CAPT
      base = src_idx;
      run(16'd12, {16'd3, 16'd0, 16'd1, 16'd2}, 12, seq_a);
      c = 0;
      while (!(bus.idata_pop && (src_idx - base) == 2) && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk("r_third_pop", 64'(bus.idata_pop), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k < NCH; k++) obs_push[k] = 0;
      @(posedge clk);
      #1;
      chk("r_busy", 64'(busy), 64'd0);
      chk("r_done", 64'(done), 64'd0);
      chk("r_pop", 64'(bus.idata_pop), 64'd0);
      chk("r_push", 64'(bus.odata_push), 64'd0);
      chk("r_odata", 64'(bus.odata != '0), 64'd0);
`ifdef DATA_SPLITTER_NCH_STATS_EN
      chk("r_stat_clear", 64'(stat_cnt != '0), 64'd0);
`endif
      rst = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("r_no_done", 64'(done_cnt), 64'd0);

      run(16'd4, {4{16'd1}}, 4, seq_r);
      wait_done(100, 1'b0);
      chk("r2_pops", 64'(pop_cnt), 64'd4);
      chk("r2_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef DATA_SPLITTER_NCH_STATS_EN
      for (int k = 0; k < NCH; k++)
         chk("stat_cnt", 64'(stat_cnt[k*32 +: 32]), 64'(obs_push[k]));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
